pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameters SHALL be: REG_AW, default 5, register-address width; CNT_W, default 32, performance-counter width.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_valid  in  1  decode stage holds a real instruction.
- id_rs1, id_rs2  in  REG_AW  decode source registers.
- id_use_rs1, id_use_rs2  in  1  the corresponding source is read.
- id_rd  in  REG_AW  decode destination.
- id_regwrite, id_is_load, id_mem_req  in  1  decode writes rd / is a load / accesses data memory.
- ex_redirect  in  1  execute resolved a taken branch or jump.
- mem_ready  in  1  data memory completes the access in the memory stage this cycle.
- cnt_clr  in  1  synchronous clear of all counters.
- stall_f, stall_d  out  1  hold PC / hold the fetch-decode register.
- flush_d, flush_e  out  1  load a bubble into fetch-decode / decode-execute.
- freeze  out  1  hold the decode-execute and execute-memory registers.
- fwd_a, fwd_b  out  2  execute operand select: 00 register file, 01 memory-stage ALU result, 10 writeback data.
- valid_e, valid_m, valid_w  out  1  stage-occupancy flags.
- cnt_cycle, cnt_retired, cnt_stall, cnt_flush  out  CNT_W  performance counters.

Function
REQ-003 The block SHALL keep shadow stage records E, M and W; each record SHALL hold valid, rd, regwrite, is_load and mem_req, and E SHALL also hold rs1 and rs2.
REQ-004 A memory wait SHALL be defined as valid_m & mem_req_m & ~mem_ready.
- On a memory wait, freeze, stall_f and stall_d SHALL be 1.
- E and M SHALL hold their contents.
- W SHALL take a bubble (valid_w=0 next cycle).
- flush_d and flush_e SHALL be 0.
REQ-005 A redirect SHALL be defined as ex_redirect & valid_e & ~memory wait.
- On a redirect, flush_d and flush_e SHALL be 1.
- stall_f and stall_d SHALL be 0.
REQ-006 A load-use hazard SHALL be defined as valid_e & is_load_e & regwrite_e & rd_e!=0 & id_valid & ((id_use_rs1 & id_rs1==rd_e) | (id_use_rs2 & id_rs2==rd_e)).
- When no memory wait or redirect is active, stall_f, stall_d and flush_e SHALL be 1 for exactly one cycle.
REQ-007 Priority SHALL be memory wait > redirect > load-use; when none applies, all stall, flush and freeze outputs SHALL be 0.
REQ-008 When not in a memory wait, records SHALL advance every cycle: E <= flush_e ? bubble : decode inputs (valid=id_valid); M <= E; W <= M.
REQ-009 fwd_a SHALL be combinational from the records.
- 01 when valid_m & regwrite_m & ~is_load_m & rd_m!=0 & rd_m==rs1_e.
- Otherwise 10 when valid_w & regwrite_w & rd_w!=0 & rd_w==rs1_e.
- Otherwise 00.
- Memory-stage forwarding takes priority over writeback forwarding.
REQ-010 fwd_b SHALL follow the same rule as fwd_a using rs2_e.
REQ-011 Forwarding outputs SHALL be 00 whenever valid_e=0.
REQ-012 Counters SHALL wrap modulo 2^CNT_W, and cnt_clr SHALL take priority over increment.
- cnt_cycle increments every cycle.
- cnt_retired increments when valid_w=1.
- cnt_stall increments when stall_f=1.
- cnt_flush increments once per accepted redirect.
REQ-013 A redirect asserted during a memory wait SHALL be acted on and counted only in the first cycle after the wait ends.

Reset
REQ-014 While reset=0, all records SHALL be invalid, all stall, flush and freeze outputs and fwd_a/fwd_b SHALL be 0, and all counters SHALL be 0.
REQ-015 The reset of REQ-014 SHALL take effect immediately without a clock edge, including mid-stall and mid-memory-wait.
REQ-016 The first cycle after reset is released SHALL behave as an empty pipeline.

Structure
REQ-017 Package pipe_pkg SHALL define the fwd_sel_e enum (FWD_REG=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10) and the stage_rec_t struct.
REQ-018 Sub-module perf_counter (CNT_W, inc, clr) SHALL be instantiated four times; all other logic SHALL be flat.

Verification
REQ-019 add x5,x1,x2 followed immediately by add x6,x5,x3 -> fwd_a=01 in the consumer's execute cycle; the same consumer placed two instructions later -> fwd_a=10.
REQ-020 lw x6,0(x1) followed by add x7,x6,x2 -> stall_f=stall_d=flush_e=1 for one cycle, then fwd_a=10, and cnt_stall=1.
REQ-021 Taken beq in execute while decode holds a load-use consumer -> flush_d=flush_e=1 and stall_f=0, and cnt_flush increments by 1.
REQ-022 Load in the memory stage with mem_ready=0 for 3 cycles -> freeze=1 for exactly 3 cycles, valid_w=0 throughout, and cnt_retired increments by exactly 1 for that load.
REQ-023 Producer with rd=x0 -> fwd_a=fwd_b=00 and no load-use stall.
REQ-024 reset driven to 0 mid memory wait with counters at 0x10 -> all outputs and counters are 0 immediately, without a clock edge.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared types for the pipeline control block: forwarding selects, stage records
// and the forwarding-source pick used for both execute operands.
package pipe_pkg;

  // Record register fields are sized for the widest supported REG_AW
  localparam int unsigned REC_AW = 8;

  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_e;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
    logic              mem_req;
    logic [REC_AW-1:0] rs1;
    logic [REC_AW-1:0] rs2;
  } stage_rec_t;

  // Memory-stage ALU result wins over writeback; loads in M have no data yet
  function automatic fwd_sel_e fwd_pick(input stage_rec_t m, input stage_rec_t w,
                                        input logic [REC_AW-1:0] rs);
    if (m.valid && m.regwrite && !m.is_load && (m.rd != '0) && (m.rd == rs))
      return FWD_MEM;
    if (w.valid && w.regwrite && (w.rd != '0) && (w.rd == rs))
      return FWD_WB;
    return FWD_REG;
  endfunction

endpackage

// File: rtl/perf_counter.sv
// Wrapping event counter with synchronous clear taking priority over increment.
module perf_counter #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (inc)  cnt <= cnt + CNT_W'(1);
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline hazard control: memory-wait freeze, redirect flush,
// load-use stall, operand forwarding and performance counters.
module pipe_ctrl
  import pipe_pkg::*;
#(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_is_load,
  input  logic              id_mem_req,
  input  logic              ex_redirect,
  input  logic              mem_ready,
  input  logic              cnt_clr,
  output logic              stall_f,
  output logic              stall_d,
  output logic              flush_d,
  output logic              flush_e,
  output logic              freeze,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              valid_e,
  output logic              valid_m,
  output logic              valid_w,
  output logic [CNT_W-1:0]  cnt_cycle,
  output logic [CNT_W-1:0]  cnt_retired,
  output logic [CNT_W-1:0]  cnt_stall,
  output logic [CNT_W-1:0]  cnt_flush
);

  stage_rec_t e_rec, m_rec, w_rec, id_rec;
  logic       mem_wait, redirect, load_use;

  always_comb begin
    id_rec          = '0;
    id_rec.valid    = id_valid;
    id_rec.rd       = REC_AW'(id_rd);
    id_rec.regwrite = id_regwrite;
    id_rec.is_load  = id_is_load;
    id_rec.mem_req  = id_mem_req;
    id_rec.rs1      = REC_AW'(id_rs1);
    id_rec.rs2      = REC_AW'(id_rs2);
  end

  assign mem_wait = m_rec.valid & m_rec.mem_req & ~mem_ready;
  // A redirect held during a wait is naturally taken once the wait releases E
  assign redirect = ex_redirect & e_rec.valid & ~mem_wait;
  assign load_use = e_rec.valid & e_rec.is_load & e_rec.regwrite & (e_rec.rd != '0)
                  & id_valid
                  & ((id_use_rs1 & (id_rec.rs1 == e_rec.rd))
                   | (id_use_rs2 & (id_rec.rs2 == e_rec.rd)));

  // Hazard priority: memory wait, then redirect, then load-use
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_d = 1'b0;
    flush_e = 1'b0;
    freeze  = 1'b0;
    if (mem_wait) begin
      freeze  = 1'b1;
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (redirect) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_rec <= '0;
      m_rec <= '0;
      w_rec <= '0;
    end else if (mem_wait) begin
      w_rec <= '0;
    end else begin
      e_rec <= flush_e ? '0 : id_rec;
      m_rec <= e_rec;
      w_rec <= m_rec;
    end
  end

  assign fwd_a = e_rec.valid ? fwd_pick(m_rec, w_rec, e_rec.rs1) : FWD_REG;
  assign fwd_b = e_rec.valid ? fwd_pick(m_rec, w_rec, e_rec.rs2) : FWD_REG;

  assign valid_e = e_rec.valid;
  assign valid_m = m_rec.valid;
  assign valid_w = w_rec.valid;

  // Source fields carried past execute are kept only for record uniformity
  logic unused_bits;
  assign unused_bits = ^{m_rec.rs1, m_rec.rs2, w_rec.rs1, w_rec.rs2,
                         w_rec.is_load, w_rec.mem_req};

  perf_counter #(.CNT_W(CNT_W)) u_cnt_cycle (
    .clk(clk), .reset(reset), .inc(1'b1), .clr(cnt_clr), .cnt(cnt_cycle));
  perf_counter #(.CNT_W(CNT_W)) u_cnt_retired (
    .clk(clk), .reset(reset), .inc(valid_w), .clr(cnt_clr), .cnt(cnt_retired));
  perf_counter #(.CNT_W(CNT_W)) u_cnt_stall (
    .clk(clk), .reset(reset), .inc(stall_f), .clr(cnt_clr), .cnt(cnt_stall));
  perf_counter #(.CNT_W(CNT_W)) u_cnt_flush (
    .clk(clk), .reset(reset), .inc(redirect), .clr(cnt_clr), .cnt(cnt_flush));

endmodule
